// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the frame-level serial pattern scanner.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 6;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 6'b110110;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping bit-serial pattern matcher with a registered one-cycle hit pulse.
module seq_match_core
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic hit
);

    localparam int SEEN_W = $clog2(PAT_W);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [SEEN_W-1:0] seen;
    logic [PAT_W-1:0]  window;
    logic              match;

    // seen gates the compare until the history holds PAT_W-1 real bits
    assign window = {hist, bit_in};
    assign match  = bit_vld && (seen == SEEN_MAX) && (window == PATTERN);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            seen <= '0;
            hit  <= 1'b0;
        end else begin
            hit <= match;
            if (bit_vld) begin
                hist <= window[PAT_W-2:0];
                if (seen != SEEN_MAX)
                    seen <= seen + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts words over valid/ready, serializes them MSB-first
// into the matcher, counts detections and flags frame completion.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              hit,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  words_left;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  cnt_q;
    logic              clr;
    logic              accept;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = (frame_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                if (bit_idx == '0)
                    state_nxt = (words_left != '0) ? LOAD : DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign bit_out = bit_valid && word[bit_idx];

    // hit and match_cnt must move together, so the count is presented
    // combinationally from the registered total plus the pending hit
    assign match_cnt = (hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            words_left <= '0;
            bit_idx    <= '0;
            cnt_q      <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                words_left <= frame_len;
                cnt_q      <= '0;
            end else begin
                cnt_q <= match_cnt;
            end
            if (accept) begin
                words_left <= words_left - 1'b1;
                bit_idx    <= IDX_TOP;
            end else if (bit_valid && (bit_idx != '0)) begin
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            word <= in_data;
    end

    seq_match_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .bit_in  (bit_out),
        .bit_vld (bit_valid),
        .hit     (hit)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed frames plus random frames against a stream-level model.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] frame_len;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready, bit_out, bit_valid, hit, busy, done;
    logic [7:0] match_cnt;
    logic       in_ready2, bit_out2, bit_valid2, hit2, busy2, done2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [7:0] fw[$];
    localparam logic [5:0] PAT = 6'b110110;

    always #5 clk = ~clk;

    seq_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .hit(hit),
        .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    seq_scan_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .bit_out(bit_out2), .bit_valid(bit_valid2), .hit(hit2),
        .match_cnt(match_cnt2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic run_frame(input string tag, input int stall_word, input int stall_n,
                             input int restart_at, input int rst_at_bit);
        int   len, wi, stall_left, start_cyc, done_cyc, bits_seen;
        int   nhit, nhit2, rdy_seen, bad;
        bit   done_seen;
        logic sbits[$];
        logic mbits[$];
        int   exp_pos[$];
        int   got_pos[$];
        logic [5:0] win;

        len = fw.size();
        foreach (fw[i])
            for (int b = 7; b >= 0; b--)
                mbits.push_back(fw[i][b]);
        for (int i = 5; i < mbits.size(); i++) begin
            win = {mbits[i-5], mbits[i-4], mbits[i-3], mbits[i-2], mbits[i-1], mbits[i]};
            if (win == PAT)
                exp_pos.push_back(i);
        end

        wi = 0; stall_left = stall_n; bits_seen = 0; nhit = 0; nhit2 = 0;
        rdy_seen = 0; done_seen = 0; done_cyc = 0;
        start = 1'b1; frame_len = 8'(len); in_valid = 1'b0; start_cyc = cyc;
        tick();
        start = 1'b0;

        for (int k = 0; k < 400 && !done_seen; k++) begin
            if (hit) begin
                got_pos.push_back(bits_seen - 1);
                nhit++;
                chk({tag, " cnt_at_hit"}, match_cnt, sat(nhit, 255));
            end
            if (hit2) nhit2++;
            if (bit_valid) begin
                sbits.push_back(bit_out);
                bits_seen++;
            end
            if (in_ready) rdy_seen++;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            if (rst_at_bit > 0 && bit_valid && bits_seen == rst_at_bit) begin
                rst = 1'b1; in_valid = 1'b0;
                tick();
                rst = 1'b0;
                chk({tag, " rst_busy"}, busy, 0);
                chk({tag, " rst_ready"}, in_ready, 0);
                chk({tag, " rst_cnt"}, match_cnt, 0);
                chk({tag, " rst_cnt_sat"}, match_cnt2, 0);
                chk({tag, " rst_done"}, done, 0);
                bad = 0;
                for (int j = 0; j < 12; j++) begin
                    tick();
                    if (done || busy) bad++;
                end
                chk({tag, " rst_quiet"}, bad, 0);
                return;
            end
            if (!done_seen) begin
                start = (restart_at > 0 && cyc - start_cyc == restart_at);
                if (start) frame_len = 8'd3;
                if (wi < len) begin
                    in_data = fw[wi];
                    if (in_ready && wi == stall_word && stall_left > 0) begin
                        in_valid = 1'b0;
                        stall_left--;
                    end else begin
                        in_valid = 1'b1;
                        if (in_ready) wi++;
                    end
                end else begin
                    in_valid = 1'b0;
                end
                tick();
            end
        end

        chk({tag, " done_seen"}, done_seen, 1);
        chk({tag, " done_latency"}, done_cyc - start_cyc, len * 9 + 1 + stall_n);
        chk({tag, " hits"}, nhit, exp_pos.size());
        chk({tag, " hits_sat_inst"}, nhit2, exp_pos.size());
        foreach (exp_pos[i])
            chk({tag, " hit_pos"}, (i < got_pos.size()) ? got_pos[i] : -1, exp_pos[i]);
        chk({tag, " nbits"}, sbits.size(), len * 8);
        bad = 0;
        foreach (mbits[i])
            if (i >= sbits.size() || sbits[i] !== mbits[i]) bad++;
        chk({tag, " stream"}, bad, 0);
        chk({tag, " cnt_done"}, match_cnt, sat(exp_pos.size(), 255));
        chk({tag, " cnt_done_sat"}, match_cnt2, sat(exp_pos.size(), 3));
        if (len == 0) chk({tag, " no_ready"}, rdy_seen, 0);
        in_valid = 1'b0; start = 1'b0;
        tick();
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " cnt_hold"}, match_cnt, sat(exp_pos.size(), 255));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        chk("reset in_ready", in_ready, 0);
        chk("reset bit_out", bit_out, 0);
        chk("reset bit_valid", bit_valid, 0);
        chk("reset hit", hit, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset match_cnt", match_cnt, 0);
        rst = 1'b0;
        tick();

        fw = '{8'b11011000};
        run_frame("single", -1, 0, -1, -1);

        fw = '{8'b11011011, 8'b01100000};
        run_frame("overlap", -1, 0, -1, -1);

        fw = {};
        run_frame("zero_len", -1, 0, -1, -1);

        fw = '{8'b11011000};
        run_frame("ignored_start", -1, 0, 4, -1);

        fw = '{8'b11011011, 8'b01100000};
        run_frame("stall", 1, 5, -1, -1);

        fw = '{8'hDB, 8'h6D, 8'hB6};
        run_frame("saturate", -1, 0, -1, -1);

        fw = '{8'b11011011, 8'b01100000};
        run_frame("mid_reset", -1, 0, -1, 4);

        fw = '{8'b11011000};
        run_frame("after_reset", -1, 0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 4);
            fw = {};
            for (int i = 0; i < n; i++)
                fw.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'hDB ^ 8'(1 << $urandom_range(0, 7)));
            run_frame("random", $urandom_range(0, n - 1), $urandom_range(0, 4), -1, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
